dpram_rdstream: RTL and testbench

- Sequential reader for the dual-port RAM's read-only X port; it is the consumer end of data written through port A.
- On a start command it walks a contiguous, wrapping address range and streams each word out on a valid/ready (stb/ack) interface.
- Sits between the dual-port RAM and any downstream consumer, such as a serialiser or compare engine.
- The RAM's X port reads asynchronously, so this block drives the X address and registers the returned word into its output stage.

---
 rtl/dpram_rdstream.sv | 116 +++++++++++
 tb/tb_dpram_rdstream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rdstream.sv
// Sequential burst reader for the dual-port RAM X port.
// Walks a wrapping address range and streams the words out over a stb/ack handshake.
module dpram_rdstream #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] xadr_o,
  input  logic [DW-1:0] xdat_i,
  output logic [DW-1:0] dat_o,
  output logic          stb_o,
  input  logic          ack_i
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] xadr_q, xadr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          stb_q, stb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load;

  // State register; every register holds while ena_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      xadr_q  <= '0;
      rem_q   <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena_i) begin
      state_q <= state_d;
      xadr_q  <= xadr_d;
      rem_q   <= rem_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A word is fetched whenever words remain and the output stage is empty or draining.
  assign load = (state_q == StRun) && (rem_q != '0) && (!stb_q || ack_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_i && (len_i != '0)) state_d = StRun;
      end
      StRun: begin
        if ((rem_q == '0) && stb_q && ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    xadr_d = xadr_q;
    rem_d  = rem_q;
    dat_d  = dat_q;
    stb_d  = stb_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i != '0) begin
            xadr_d = base_i;
            rem_d  = len_i;
            busy_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (load) begin
          dat_d  = xdat_i;
          stb_d  = 1'b1;
          xadr_d = xadr_q + AW'(1);
          rem_d  = rem_q - (AW+1)'(1);
        end else if (stb_q && ack_i) begin
          stb_d = 1'b0;
          if (rem_q == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        stb_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign xadr_o = xadr_q;
  assign dat_o  = dat_q;
  assign stb_o  = stb_q;

endmodule

// File: tb/tb_dpram_rdstream.sv
// Randomized self-checking bench for dpram_rdstream against a RAM-image reference model.
module tb_dpram_rdstream;
  localparam int AW = 5;
  localparam int DW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, stb, ack = 1'b0;
  logic [AW-1:0] xadr;
  logic [DW-1:0] xdat, dat;
  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad = 0;

  assign xdat = mem[xadr];

  always #5 clk = ~clk;

  dpram_rdstream #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .start_i(start), .base_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .xadr_o(xadr), .xdat_i(xdat), .dat_o(dat), .stb_o(stb),
    .ack_i(ack)
  );

  // Issue one burst and check every presented word against the RAM image.
  // Patterns (LSB first) drive ack/ena when their length is nonzero, else random percentages.
  task automatic do_burst(input int b, input int n, input logic [31:0] ack_pat, input int ack_n,
                          input logic [31:0] ena_pat, input int ena_n, input int ack_pct,
                          input int ena_pct);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_dat;
    bit prev_hold;
    int got, cyc;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    @(negedge clk);
    start = 1'b1; base = AW'(b); len = (AW+1)'(n); ena = 1'b1; ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || stb !== 1'b0) begin
        bad++;
        $display("FAIL zero_len_done: done=%b busy=%b stb=%b required 1/0/0", done, busy, stb);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || stb !== 1'b0) begin
        bad++;
        $display("FAIL zero_len_after: done=%b busy=%b stb=%b required 0/0/0", done, busy, stb);
      end
      return;
    end
    total++;
    if (busy !== 1'b1 || stb !== 1'b0 || xadr !== AW'(b)) begin
      bad++;
      $display("FAIL start_state: busy=%b stb=%b xadr=%0d required 1/0/%0d", busy, stb, xadr, b);
    end
    got = 0; cyc = 0; prev_hold = 0; prev_dat = '0;
    while (got < n && cyc < 500) begin
      ack = (ack_n > 0) ? ack_pat[cyc % ack_n] : ($urandom_range(0, 99) < ack_pct);
      ena = (ena_n > 0) ? ena_pat[cyc % ena_n] : ($urandom_range(0, 99) < ena_pct);
      #1;
      if (prev_hold) begin
        total++;
        if (stb !== 1'b1 || dat !== prev_dat) begin
          bad++;
          $display("FAIL hold: stb=%b dat=%0d required 1/%0d", stb, dat, prev_dat);
        end
      end
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL mid_burst: done=%b busy=%b required 0/1", done, busy);
      end
      if (stb === 1'b1) begin
        total++;
        if (dat !== exp_q[got] || xadr !== AW'((b + got + 1) % DEPTH)) begin
          bad++;
          $display("FAIL word%0d: dat=%0d xadr=%0d required %0d/%0d", got, dat, xadr,
                   exp_q[got], (b + got + 1) % DEPTH);
        end
      end
      prev_hold = (stb === 1'b1) && !(ack && ena);
      prev_dat = dat;
      if (stb === 1'b1 && ack && ena) got++;
      cyc++;
      @(negedge clk);
    end
    if (got < n) begin
      total++; bad++;
      $display("FAIL timeout: words=%0d required %0d", got, n);
    end
    ena = 1'b1; ack = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || stb !== 1'b0) begin
      bad++;
      $display("FAIL end_done: done=%b busy=%b stb=%b required 1/0/0", done, busy, stb);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || stb !== 1'b0) begin
      bad++;
      $display("FAIL done_once: done=%b stb=%b required 0/0", done, stb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 0 || done !== 0 || stb !== 0 || xadr !== '0 || dat !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b stb=%b xadr=%0d dat=%0d required all 0",
               busy, done, stb, xadr, dat);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    mem[3] = 2'd1; mem[4] = 2'd2; mem[5] = 2'd3; mem[6] = 2'd0;
    do_burst(3, 4, 32'h1, 1, 32'h1, 1, 0, 0);
  endtask

  task automatic test_wrap();
    do_burst(30, 4, 32'h1, 1, 32'h1, 1, 0, 0);
  endtask

  task automatic test_backpressure();
    do_burst(12, 4, 32'h59, 7, 32'h1, 1, 0, 0);
  endtask

  task automatic test_zero_len();
    do_burst(9, 0, 32'h1, 1, 32'h1, 1, 0, 0);
  endtask

  task automatic test_enable();
    do_burst(20, 6, 32'h1, 1, 32'hFFFF_FFE3, 32, 0, 0);
  endtask

  task automatic test_full();
    do_burst(7, DEPTH, 32'h0, 0, 32'h0, 0, 70, 85);
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1; base = AW'(5); len = (AW+1)'(6); ack = 1'b0; ena = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 0 || done !== 0 || stb !== 0 || xadr !== '0 || dat !== '0) begin
      bad++;
      $display("FAIL abort_clear: busy=%b done=%b stb=%b xadr=%0d dat=%0d required all 0",
               busy, done, stb, xadr, dat);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_done: done=%b busy=%b required 0/0", done, busy);
      end
    end
    do_burst(0, 2, 32'h1, 1, 32'h1, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 32'h0, 0, 32'h0, 0,
               $urandom_range(30, 100), $urandom_range(50, 100));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_enable();
    test_full();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
